// File: rtl/cache_ctrl.sv
// Cache management unit: turns CPU requests into cache lookup/edit strobes and
// handles dirty-victim write-back and block refill for a 2-way write-back cache.
module cache_ctrl #(
    parameter int unsigned ADDR_BITS           = 32,
    parameter int unsigned TAG_BITS            = 23,
    parameter int unsigned SET_INDEX_WIDTH     = 5,
    parameter int unsigned ELEMENT_WORDS_WIDTH = 2,
    parameter int unsigned WORD_BYTES_WIDTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int unsigned OFF_W = ELEMENT_WORDS_WIDTH + WORD_BYTES_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        WB_RD  = 3'd2,
        WB_WR  = 3'd3,
        FILL   = 3'd4,
        REPLAY = 3'd5
    } state_e;

    state_e                         state_q, state_d;
    logic [ELEMENT_WORDS_WIDTH-1:0] cnt_q, cnt_d;
    logic [TAG_BITS-1:0]            victim_tag_q, victim_tag_d;

    logic                       req;
    logic                       cnt_last;
    logic [TAG_BITS-1:0]        req_tag;
    logic [SET_INDEX_WIDTH-1:0] set_index;
    logic [ADDR_BITS-1:0]       req_word_addr;
    logic [ADDR_BITS-1:0]       victim_word_addr;

    assign req       = en_r | en_w;
    assign cnt_last  = (cnt_q == '1);
    assign req_tag   = addr_rw[ADDR_BITS-1 -: TAG_BITS];
    assign set_index = addr_rw[OFF_W +: SET_INDEX_WIDTH];

    // Word addresses of the current block word, for the requested and the evicted tag
    assign req_word_addr    = {req_tag, set_index, cnt_q, {WORD_BYTES_WIDTH{1'b0}}};
    assign victim_word_addr = {victim_tag_q, set_index, cnt_q, {WORD_BYTES_WIDTH{1'b0}}};

    assign data_r        = cache_dout;
    assign mem_data_o    = cache_dout;
    assign cache_invalid = 1'b0;
    assign cache_u_b_h_w = u_b_h_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        cnt_d        = cnt_q;
        victim_tag_d = victim_tag_q;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = CHECK;
            end
            CHECK: begin
                if (cache_hit) begin
                    state_d = IDLE;
                end else if (cache_valid && cache_dirty) begin
                    victim_tag_d = cache_tag;
                    cnt_d        = '0;
                    state_d      = WB_RD;
                end else begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            WB_RD: state_d = WB_WR;
            WB_WR: begin
                if (mem_ack_i) begin
                    cnt_d   = cnt_q + ELEMENT_WORDS_WIDTH'(1);
                    state_d = cnt_last ? FILL : WB_RD;
                end
            end
            FILL: begin
                if (mem_ack_i) begin
                    cnt_d = cnt_q + ELEMENT_WORDS_WIDTH'(1);
                    if (cnt_last) state_d = REPLAY;
                end
            end
            REPLAY:  state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        cache_addr  = addr_rw;
        cache_load  = 1'b0;
        cache_edit  = 1'b0;
        cache_store = 1'b0;
        cache_din   = data_w;
        stall       = 1'b1;
        mem_cs_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = req_word_addr;
        unique case (state_q)
            IDLE: begin
                cache_load = en_r & ~en_w;
                cache_edit = en_w;
                stall      = req;
            end
            REPLAY: begin
                cache_load = en_r & ~en_w;
                cache_edit = en_w;
            end
            CHECK: stall = ~cache_hit;
            WB_RD: cache_addr = req_word_addr;
            WB_WR: begin
                // cache_addr stays on the victim word so cache_dout keeps presenting it
                cache_addr = req_word_addr;
                mem_cs_o   = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = victim_word_addr;
            end
            FILL: begin
                cache_addr  = req_word_addr;
                mem_cs_o    = 1'b1;
                cache_store = mem_ack_i;
                if (mem_ack_i) cache_din = mem_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache array and memory around the DUT,
// checked against an architectural memory image with a per-set recency list.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] addr_rw, data_w, data_r;
    logic        en_r, en_w, stall;
    logic [2:0]  u_b_h_w, cache_u_b_h_w;
    logic [31:0] cache_addr, cache_din, cache_dout;
    logic        cache_load, cache_edit, cache_store, cache_invalid;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;
    logic        mem_cs_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

    int n_checks;
    int n_errors;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
        .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
        .cache_store(cache_store), .cache_invalid(cache_invalid),
        .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag), .cache_dout(cache_dout),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always begin
        clk = 1'b0; #5;
        clk = 1'b1; #5;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] ubhw);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (ubhw[1:0])
            2'b00:   return ubhw[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return ubhw[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] ubhw, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (ubhw[1:0])
            2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
            2'b01:   if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // ---------------- behavioural cache array (registered outputs) ----------------
    logic [22:0] c_tag   [32][2];
    logic        c_valid [32][2];
    logic        c_dirty [32][2];
    logic [31:0] c_data  [32][2][4];
    logic        c_lru   [32];
    int          n_store;

    logic [31:0] s_addr = '0, s_din = '0;
    logic        s_load = 1'b0, s_edit = 1'b0, s_store = 1'b0;
    logic [2:0]  s_ubhw = '0;

    // DUT strobes are captured just before the active edge to avoid races
    always @(negedge clk) begin
        #4;
        s_addr  = cache_addr;
        s_din   = cache_din;
        s_load  = cache_load;
        s_edit  = cache_edit;
        s_store = cache_store;
        s_ubhw  = cache_u_b_h_w;
    end

    always @(posedge clk) begin : cache_array
        int          set, wrd, way, vic;
        logic        hit;
        logic [22:0] tg;
        set = int'(s_addr[8:4]);
        wrd = int'(s_addr[3:2]);
        tg  = s_addr[31:9];
        hit = 1'b0;
        way = 0;
        for (int i = 0; i < 2; i++)
            if (c_valid[set][i] && c_tag[set][i] == tg) begin
                hit = 1'b1;
                way = i;
            end
        vic = c_lru[set] ? 1 : 0;
        cache_hit   <= (s_load | s_edit) & hit;
        cache_valid <= c_valid[set][vic];
        cache_dirty <= c_dirty[set][vic];
        cache_tag   <= c_tag[set][vic];
        if (s_load && hit) cache_dout <= load_fmt(c_data[set][way][wrd], s_addr[1:0], s_ubhw);
        else               cache_dout <= c_data[set][vic][wrd];
        if (s_edit && hit) begin
            c_data[set][way][wrd] = st_merge(c_data[set][way][wrd], s_addr[1:0], s_ubhw, s_din);
            c_dirty[set][way]     = 1'b1;
            c_lru[set]            = (way == 0);
        end else if (s_load && hit) begin
            c_lru[set] = (way == 0);
        end
        if (s_store) begin
            c_data[set][vic][wrd] = s_din;
            c_tag[set][vic]       = tg;
            c_valid[set][vic]     = 1'b1;
            c_dirty[set][vic]     = 1'b0;
            n_store++;
        end
    end

    // ---------------- behavioural main memory ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mtx_t;

    logic [31:0] bmem [logic [31:0]];
    mtx_t        mlog[$];
    int          mem_lat;
    int          wait_cnt;

    always @(negedge clk) begin : memory
        mtx_t t;
        mem_ack_i = 1'b0;
        if (mem_cs_o) begin
            if (wait_cnt >= mem_lat) begin
                wait_cnt = 0;
                mem_ack_i = 1'b1;
                if (mem_we_o) begin
                    bmem[mem_addr_o] = mem_data_o;
                    t.data = mem_data_o;
                end else begin
                    mem_data_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : mem_default(mem_addr_o);
                    t.data = mem_data_i;
                end
                t.we   = mem_we_o;
                t.addr = mem_addr_o;
                mlog.push_back(t);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- reference model: CPU-visible memory + recency per set ----------------
    logic [31:0] ref_mem [logic [31:0]];
    bit          r_dirty [logic [31:0]];
    logic [22:0] r_mru   [32][2];
    int          r_cnt   [32];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    task automatic cpu_access(input bit wr, input logic [31:0] a, input logic [2:0] ubhw,
                              input logic [31:0] wd, input int lat);
        int          s, pos, ncyc, st0, exp_stall, n;
        bit          hit, dirty_ev, done;
        logic [22:0] tg;
        logic [31:0] blk, vblk, wa, exp_rd;
        mtx_t        exp_q[$];
        mtx_t        e;
        s     = int'(a[8:4]);
        tg    = a[31:9];
        blk   = {a[31:4], 4'h0};
        wa    = {a[31:2], 2'b00};
        hit   = 1'b0;
        pos   = 0;
        dirty_ev = 1'b0;
        exp_rd = '0;
        for (int i = 0; i < r_cnt[s]; i++)
            if (r_mru[s][i] == tg) begin hit = 1'b1; pos = i; end
        if (hit) begin
            if (pos == 1) begin r_mru[s][1] = r_mru[s][0]; r_mru[s][0] = tg; end
        end else begin
            if (r_cnt[s] == 2) begin
                vblk = {r_mru[s][1], 5'(s), 4'h0};
                if (r_dirty.exists(vblk)) begin
                    dirty_ev = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        e.we = 1'b1; e.addr = vblk + 32'(4*k); e.data = ref_rd(e.addr);
                        exp_q.push_back(e);
                    end
                    r_dirty.delete(vblk);
                end
            end
            for (int k = 0; k < 4; k++) begin
                e.we = 1'b0; e.addr = blk + 32'(4*k); e.data = ref_rd(e.addr);
                exp_q.push_back(e);
            end
            r_mru[s][1] = r_mru[s][0];
            r_mru[s][0] = tg;
            if (r_cnt[s] < 2) r_cnt[s]++;
        end
        exp_stall = hit ? 1 : 3 + 4*(lat+1) + (dirty_ev ? 4*(lat+2) : 0);
        if (wr) begin
            ref_mem[wa] = st_merge(ref_rd(wa), a[1:0], ubhw, wd);
            r_dirty[blk] = 1'b1;
        end else begin
            exp_rd = load_fmt(ref_rd(wa), a[1:0], ubhw);
        end

        @(negedge clk);
        mlog.delete();
        st0     = n_store;
        mem_lat = lat;
        addr_rw = a;
        u_b_h_w = ubhw;
        data_w  = wd;
        en_w    = wr;
        en_r    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        ncyc = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (!stall) done = 1'b1;
            else begin ncyc++; @(negedge clk); end
        end
        check_eq("done", 32'(done), 32'd1);
        if (!wr) check_eq("data_r", data_r, exp_rd);
        en_r = 1'b0;
        en_w = 1'b0;
        check_eq("stall_cycles", 32'(ncyc), 32'(exp_stall));
        check_eq("mem_txns", 32'(mlog.size()), 32'(exp_q.size()));
        n = (mlog.size() < exp_q.size()) ? mlog.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq("mem_we", 32'(mlog[i].we), 32'(exp_q[i].we));
            check_eq("mem_addr", mlog[i].addr, exp_q[i].addr);
            check_eq("mem_data", mlog[i].data, exp_q[i].data);
        end
        check_eq("stores", 32'(n_store - st0), hit ? 32'd0 : 32'd4);
    endtask

    initial begin
        logic [31:0] a;
        int          sz, off;
        n_checks = 0;
        n_errors = 0;
        n_store  = 0;
        mem_lat  = 0;
        wait_cnt = 0;
        for (int s = 0; s < 32; s++) begin
            c_lru[s] = 1'b0;
            r_cnt[s] = 0;
            for (int w = 0; w < 2; w++) begin
                c_valid[s][w] = 1'b0;
                c_dirty[s][w] = 1'b0;
                c_tag[s][w]   = '0;
                for (int k = 0; k < 4; k++) c_data[s][w][k] = '0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            bmem[32'h40 + 32'(4*k)]    = 32'h11 * 32'(k+1);
            ref_mem[32'h40 + 32'(4*k)] = 32'h11 * 32'(k+1);
        end
        bmem[32'h80]    = 32'h0000_0080;
        ref_mem[32'h80] = 32'h0000_0080;

        rst = 1'b1; en_r = 1'b0; en_w = 1'b0;
        addr_rw = '0; data_w = '0; u_b_h_w = 3'b010;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_cs", 32'(mem_cs_o), 32'd0);
        check_eq("rst_we", 32'(mem_we_o), 32'd0);
        check_eq("rst_load", 32'(cache_load), 32'd0);
        check_eq("rst_edit", 32'(cache_edit), 32'd0);
        check_eq("rst_store", 32'(cache_store), 32'd0);
        check_eq("rst_invalid", 32'(cache_invalid), 32'd0);

        cpu_access(1'b0, 32'h40,   3'b010, 32'h0, 0);          // cold read
        cpu_access(1'b0, 32'h48,   3'b010, 32'h0, 0);          // read hit
        cpu_access(1'b1, 32'h40,   3'b010, 32'hDEAD_BEEF, 0);  // write hit
        cpu_access(1'b0, 32'h240,  3'b010, 32'h0, 1);          // fill other way
        cpu_access(1'b0, 32'h440,  3'b010, 32'h0, 1);          // dirty eviction of 0x40
        cpu_access(1'b0, 32'h80,   3'b000, 32'h0, 0);          // lb
        cpu_access(1'b0, 32'h80,   3'b100, 32'h0, 0);          // lbu
        cpu_access(1'b0, 32'h1000, 3'b010, 32'h0, 5);          // memory wait states
        cpu_access(1'b1, 32'h1004, 3'b001, 32'hFFFF_8001, 2);  // write hit, half
        cpu_access(1'b0, 32'h1006, 3'b001, 32'h0, 0);

        for (int i = 0; i < 200; i++) begin
            sz  = $urandom_range(0, 2);
            off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2*$urandom_range(0, 1) : 0;
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'(off);
            cpu_access(1'($urandom_range(0, 1)), a, {1'($urandom_range(0, 1)), 2'(sz)},
                       $urandom, $urandom_range(0, 3));
        end

        // reset in the middle of a refill
        @(negedge clk);
        mlog.delete();
        mem_lat = 2;
        addr_rw = 32'h0000_FE70;
        u_b_h_w = 3'b010;
        en_r    = 1'b1;
        begin
            int  c;
            c = 0;
            while (mlog.size() < 2 && c < 200) begin
                @(negedge clk);
                #1;
                c++;
            end
            check_eq("midfill_acks", 32'(mlog.size()), 32'd2);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midfill_cs", 32'(mem_cs_o), 32'd0);
        check_eq("midfill_stall", 32'(stall), 32'd1);
        check_eq("midfill_load", 32'(cache_load), 32'd1);
        en_r = 1'b0;
        #1;
        check_eq("midfill_stall_noreq", 32'(stall), 32'd0);
        check_eq("midfill_load_noreq", 32'(cache_load), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
